csel_serial_subtractor: RTL and testbench
=========================================

# csel_serial_subtractor

Nibble-serial subtractor computing `diff = a - b - bin` over a WIDTH-bit operand pair, one 4-bit carry-select slice per clock. It is the subtracting counterpart to the team's 4-bit carry-select adder, and it trades latency for area on wide datapaths. It sits behind a start/done handshake so control FSMs can issue operations and collect results.

## Interface
- `WIDTH`, default 16: operand width; must be a multiple of 4 and at least 4. `N = WIDTH/4` nibbles.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; `a`, `b`, `bin` are sampled when accepted.
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  borrow in.
- `busy`  out  1  high while nibbles are being processed.
- `done`  out  1  one-cycle pulse; results are valid from this cycle onward.
- `diff`  out  WIDTH  difference.
- `bout`  out  1  borrow out (1 = unsigned underflow).
- `ovf`  out  1  signed overflow; present only with `CSSUB_OVF_EN`.

## Operation
- Reset: state IDLE, `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0, nibble counter 0, operand registers 0.
- States:
  - IDLE: if `start`=1, latch `a`, `b`, `bin`; set carry = ~`bin`, counter = 0; go to BUSY.
  - BUSY: process nibble `k` = counter.
    - Compute `a[k] + ~b[k]` with both carry-in 0 and carry-in 1.
    - Select the pair using the registered carry.
    - Write the 4 sum bits into `diff[4k+3:4k]`; register the selected carry-out.
    - When k = N-1, go to DONE; otherwise increment the counter.
  - DONE: `done`=1 and `bout` = ~final carry. If `start`=1, accept a new operation exactly as in IDLE (→ BUSY); otherwise → IDLE.
- Arithmetic:
  - Two's-complement subtract, modulo 2^WIDTH.
  - `bout` = 1 iff {1'b0,a} < {1'b0,b} + bin.
- Overflow: `ovf` = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), registered with `bout`.
- `start` in BUSY is ignored: no queuing, and operands are not re-sampled.
- `diff`, `bout`, `ovf` hold their values until the next accepted `start`. `diff` updates nibble by nibble during BUSY and is only meaningful when `done`=1 or later.
- `rst` during BUSY or DONE: immediate return to reset values; the aborted operation never produces a `done` pulse.

## Timing
- `start` accepted at edge T → `busy`=1 in cycles T+1 … T+N.
- `done`=1 in cycle T+N+1 only; `busy`=0 in that cycle.
- Latency from start to done is N+1 cycles (5 for WIDTH=16). Throughput is one operation per N+1 cycles using back-to-back starts in DONE.
- `done` is never high for two consecutive cycles.
- The critical path is one 4-bit ripple adder plus a 2:1 mux, independent of WIDTH.

## Configuration
- `CSSUB_OVF_EN`:
  - Defined: `ovf` port and logic exist, reset to 0, and update in the DONE cycle.
  - Undefined: the port is absent and there is no overflow logic. All other behaviour is identical.

## Structure
- Package `csel_pkg`:
  - `NIB_W` = 4.
  - State enum `cssub_state_t` {IDLE, BUSY, DONE}.
  - Counter-width helper `$clog2(N)` with a minimum of 1.
- Sub-module `csel_nibble`: combinational 4-bit carry-select slice.
  - Inputs: `x[3:0]`, `y[3:0]`, `cin`.
  - Outputs: `s[3:0]`, `cout`.
  - Internally two ripple adders with carry-in 0 and 1, plus output muxes.
  - Instantiated once; fed `a[k]`, `~b[k]` and the registered carry.
- Top level contains the FSM, nibble counter, operand/result registers and optional overflow logic.

## Test plan
All cases use WIDTH=16, N=4.
- `a`=0x1234, `b`=0x0234, `bin`=0, start at T → `busy` high T+1..T+4; at T+5 `done`=1, `diff`=0x1000, `bout`=0.
- `a`=0x0000, `b`=0x0001, `bin`=0 → `diff`=0xFFFF, `bout`=1; `ovf`=0.
- `a`=0x8000, `b`=0x0001 → `diff`=0x7FFF, `bout`=0, `ovf`=1 (with `CSSUB_OVF_EN`). Also check `a`=0x0005, `b`=0x0003, `bin`=1 → `diff`=0x0001.
- Back-to-back start:
  - Start 0x00FF−0x000F, then start 0x0010−0x0001 in its DONE cycle.
  - Expect done pulses 5 cycles apart with `diff`=0x00F0 then 0x000F.
  - `start` pulses during BUSY are ignored.
- Reset abort:
  - Start 0xFFFF−0x0001, then assert `rst` at T+2.
  - Expect `busy`=0, `diff`=0, `bout`=0 from T+3, and no `done` pulse.
  - A subsequent start completes normally.
- Carry-select exhaustion: random `a`/`b`/`bin` (≥10k vectors) against a reference model; every nibble boundary is exercised with borrow 0 and 1.

Source files
------------

// File: rtl/csel_pkg.sv
// ----------------------------------------------------------------------------
// csel_pkg
// Shared definitions for the nibble-serial carry-select subtractor:
//   NIB_W          slice width processed per clock
//   cssub_state_t  control FSM states
//   cnt_w()        nibble-counter width for a given nibble count (minimum 1)
// ----------------------------------------------------------------------------
package csel_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } cssub_state_t;

    // Counter width for n nibbles; a single-nibble datapath still needs one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/csel_nibble.sv
// ----------------------------------------------------------------------------
// csel_nibble
// Combinational 4-bit carry-select slice: two ripple adders (carry-in 0 and 1)
// evaluated in parallel, with the result pair chosen by cin.
//   x, y  in  4  addends
//   cin   in  1  selects between the precomputed carry-in 0 / 1 results
//   s     out 4  sum
//   cout  out 1  carry out
// ----------------------------------------------------------------------------
module csel_nibble
    import csel_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W-1:0] s0, s1;
    logic [NIB_W:0]   c0, c1;

    always_comb begin
        s0    = '0;
        s1    = '0;
        c0    = '0;
        c1    = '0;
        c0[0] = 1'b0;
        c1[0] = 1'b1;
        for (int unsigned i = 0; i < NIB_W; i++) begin
            s0[i]   = x[i] ^ y[i] ^ c0[i];
            c0[i+1] = (x[i] & y[i]) | (c0[i] & (x[i] ^ y[i]));
            s1[i]   = x[i] ^ y[i] ^ c1[i];
            c1[i+1] = (x[i] & y[i]) | (c1[i] & (x[i] ^ y[i]));
        end
    end

    assign s    = cin ? s1 : s0;
    assign cout = cin ? c1[NIB_W] : c0[NIB_W];

endmodule

// File: rtl/csel_serial_subtractor.sv
// ----------------------------------------------------------------------------
// csel_serial_subtractor
// Nibble-serial subtractor: diff = a - b - bin (mod 2^WIDTH), one 4-bit
// carry-select slice per clock, behind a start/done handshake.
// Latency start->done is WIDTH/4 + 1 cycles.
//   WIDTH  param  operand width, multiple of 4, >= 4
//   clk    in  1      rising-edge clock
//   rst    in  1      synchronous active-high reset
//   start  in  1      request; operands sampled when accepted (IDLE or DONE)
//   a, b   in  WIDTH  minuend / subtrahend
//   bin    in  1      borrow in
//   busy   out 1      nibbles being processed
//   done   out 1      one-cycle pulse, results valid from here on
//   diff   out WIDTH  difference
//   bout   out 1      borrow out (unsigned underflow)
//   ovf    out 1      signed overflow, only when CSSUB_OVF_EN is defined
// Macro: CSSUB_OVF_EN enables the ovf port and its logic.
// ----------------------------------------------------------------------------
module csel_serial_subtractor
    import csel_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef CSSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N  = WIDTH / NIB_W;
    localparam int unsigned CW = cnt_w(N);

    cssub_state_t     state_q, state_d;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] a_q, b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    int unsigned      base;
    logic [NIB_W-1:0] x_n, y_n, s_n;
    logic             cout_n;

    // Subtraction as a + ~b + ~bin: the borrow chain is the inverted carry chain.
    assign base = 32'(cnt_q) * NIB_W;
    assign x_n  = a_q[base +: NIB_W];
    assign y_n  = ~b_q[base +: NIB_W];
    assign last = (cnt_q == CW'(N - 1));

    csel_nibble u_nib (
        .x    (x_n),
        .y    (y_n),
        .cin  (carry_q),
        .s    (s_n),
        .cout (cout_n)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == BUSY);
    assign done = (state_q == DONE);

    // Results for the final nibble are registered on the BUSY->DONE edge so
    // they are already valid in the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            diff    <= '0;
            bout    <= 1'b0;
`ifdef CSSUB_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= ~bin;
            cnt_q   <= '0;
        end else if (state_q == BUSY) begin
            diff[base +: NIB_W] <= s_n;
            carry_q             <= cout_n;
            if (last) begin
                bout <= ~cout_n;
`ifdef CSSUB_OVF_EN
                ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (s_n[NIB_W-1] != a_q[WIDTH-1]);
`endif
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_csel_serial_subtractor.sv
module tb_csel_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        bin;
    logic        busy, done, bout;
    logic [15:0] diff;
`ifdef CSSUB_OVF_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csel_serial_subtractor #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef CSSUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge. Returns at the negedge of the done cycle
    // (or after the cycle budget expires, with lat = 0).
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                          input bit noise,
                          output logic [15:0] rd, output logic rbo, output logic rov,
                          output int lat, output bit busyok, output logic busy_at_done);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        lat    = 0;
        busyok = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            if (!busy) busyok = 1'b0;
            if (noise && (c == 2 || c == 3)) begin
                start = 1'b1; a = 16'hFFFF; b = 16'h0000; bin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start        = 1'b0;
        rd           = diff;
        rbo          = bout;
        busy_at_done = busy;
`ifdef CSSUB_OVF_EN
        rov = ovf;
`else
        rov = 1'b0;
`endif
    endtask

    task automatic op_check(input string name, input logic [15:0] ta, input logic [15:0] tb_,
                            input logic tbin, input bit noise,
                            input logic [15:0] ed, input logic ebo, input logic eov);
        logic [15:0] rd;
        logic        rbo, rov, bad_busy;
        int          lat;
        bit          busyok;
        run_op(ta, tb_, tbin, noise, rd, rbo, rov, lat, busyok, bad_busy);
        chk({name, "_latency"}, 32'(lat), 32'd5);
        chk({name, "_busy_window"}, {31'd0, busyok}, 32'd1);
        chk({name, "_busy_at_done"}, {31'd0, bad_busy}, 32'd0);
        chk({name, "_diff"}, {16'd0, rd}, {16'd0, ed});
        chk({name, "_bout"}, {31'd0, rbo}, {31'd0, ebo});
`ifdef CSSUB_OVF_EN
        chk({name, "_ovf"}, {31'd0, rov}, {31'd0, eov});
`else
        if (rov !== 1'b0 && eov === 1'b1) $display("note: ovf disabled");
`endif
    endtask

    initial begin
        logic [15:0] rd;
        logic        rbo, rov, bad_busy, eov;
        logic [16:0] r;
        logic [15:0] ra, rb;
        logic        rbin;
        int          lat;
        bit          busyok, seen;

        tbl[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        tbl[3] = '{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0};
        tbl[4] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h0E1E, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_diff", {16'd0, diff}, 32'd0);
        chk("reset_bout", {31'd0, bout}, 32'd0);
`ifdef CSSUB_OVF_EN
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed table, each operation started from IDLE.
        for (int i = 0; i < 8; i++) begin
            op_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin, 1'b0,
                     tbl[i].d, tbl[i].bo, tbl[i].ov);
            @(negedge clk);
            chk($sformatf("vec%0d_single_done", i), {31'd0, done}, 32'd0);
        end

        // Back-to-back: second start issued in the DONE cycle, with ignored
        // start pulses (and changed operands) during BUSY.
        op_check("b2b_first", 16'h00FF, 16'h000F, 1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0);
        op_check("b2b_second", 16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_single_done", {31'd0, done}, 32'd0);
        chk("b2b_idle", {31'd0, busy}, 32'd0);

        // Leave bout=1 so the reset abort clears something visible.
        op_check("pre_abort", 16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        @(negedge clk);

        // Reset abort in the middle of an operation.
        a = 16'hFFFF; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_diff", {16'd0, diff}, 32'd0);
        chk("abort_bout", {31'd0, bout}, 32'd0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen}, 32'd0);
        op_check("after_abort", 16'h1234, 16'h0234, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Random vectors, issued back to back from each DONE cycle.
        for (int i = 0; i < 10000; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom);
            r    = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
            eov  = (ra[15] != rb[15]) && (r[15] != ra[15]);
            run_op(ra, rb, rbin, 1'b0, rd, rbo, rov, lat, busyok, bad_busy);
            total++;
            if (lat != 5 || rd !== r[15:0] || rbo !== r[16]
`ifdef CSSUB_OVF_EN
                || rov !== eov
`endif
                ) begin
                bad++;
                $display("FAIL rand%0d: a=%h b=%h bin=%b got diff=%h bout=%b ovf=%b lat=%0d expected diff=%h bout=%b ovf=%b lat=5",
                         i, ra, rb, rbin, rd, rbo, rov, lat, r[15:0], r[16], eov);
            end
            if (lat == 0) break;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
